// File: rtl/scan_frame_pkg.sv
// Shared constants, reader state encoding and flag packing for the scan frame packer.
package scan_frame_pkg;

    localparam logic [7:0] SYNC0_BYTE     = 8'hA5;
    localparam logic [7:0] SYNC1_BYTE     = 8'h5A;
    localparam int         HDR_LEN        = 8;
    localparam int         FLAG_TRUNC_BIT = 0;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_HDR,
        RD_PT,
        RD_CSUM
    } rd_state_e;

    function automatic logic [7:0] flags_byte(input logic trunc);
        logic [7:0] f;
        f                 = '0;
        f[FLAG_TRUNC_BIT] = trunc;
        return f;
    endfunction

endpackage

// File: rtl/frame_pingpong_ram.sv
// Two-bank point store: writes go to the selected bank, reads come from the other
// bank with one cycle of latency.
module frame_pingpong_ram #(
    parameter int MAX_POINTS = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic              wr_bank_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o
);

    logic [31:0] mem_q [2*MAX_POINTS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
        rd_data_o <= mem_q[{~wr_bank_i, rd_addr_i}];
    end

endmodule

// File: rtl/scan_frame_packer.sv
// Collects one revolution of target points and emits it as a framed byte stream.
// Define SCAN_FRAME_CHECKSUM_EN to append the XOR checksum byte to each frame.
module scan_frame_packer
    import scan_frame_pkg::*;
#(
    parameter int MAX_POINTS = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_en,
    input  logic        zero_flag,
    input  logic [9:0]  dust_cnt,
    input  logic        target_valid,
    input  logic [15:0] target_pos,
    input  logic [15:0] target_gray,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        frame_busy,
    output logic        overflow
);

    localparam int            CW      = ADDR_W + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_POINTS);

    logic              zf_q, wr_bank_q, trunc_q, overflow_q;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d, wr_cnt_base;
    logic              trunc_d, trunc_base;
    logic              boundary, rd_idle, has_pts, start;
    logic              wr_full, wr_en, wr_bank_eff;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       rd_data;

    rd_state_e         state_q;
    logic              tx_valid_q, busy_q, last_q, trunc_lat_q;
    logic [7:0]        tx_data_q, seq_q, next_byte;
    logic [2:0]        hdr_idx_q;
    logic [1:0]        byte_sel_q;
    logic [CW-1:0]     pt_idx_q, cnt_lat_q;
    logic [9:0]        dust_lat_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [23:0]       pt_buf_q;
    logic [15:0]       cnt16;
`ifdef SCAN_FRAME_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic              csum_en;
`endif

    assign boundary    = zero_flag & ~zf_q;
    assign rd_idle     = (state_q == RD_IDLE);
    assign has_pts     = (wr_cnt_q != '0);
    assign start       = boundary & send_en & rd_idle & has_pts;

    // A point arriving on the boundary cycle already belongs to the new revolution.
    assign wr_bank_eff = start ? ~wr_bank_q : wr_bank_q;
    assign wr_cnt_base = boundary ? '0 : wr_cnt_q;
    assign trunc_base  = boundary ? 1'b0 : trunc_q;
    assign wr_full     = (wr_cnt_base == CNT_MAX);
    assign wr_en       = target_valid & ~wr_full;
    assign wr_addr     = wr_cnt_base[ADDR_W-1:0];
    assign wr_cnt_d    = wr_en ? wr_cnt_base + 1'b1 : wr_cnt_base;
    assign trunc_d     = trunc_base | (target_valid & wr_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q       <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            trunc_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zf_q       <= zero_flag;
            wr_cnt_q   <= wr_cnt_d;
            trunc_q    <= trunc_d;
            overflow_q <= boundary & send_en & ~rd_idle & has_pts;
            if (start) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    frame_pingpong_ram #(
        .MAX_POINTS (MAX_POINTS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_bank_i (wr_bank_eff),
        .wr_addr_i (wr_addr),
        .wr_data_i ({target_pos, target_gray}),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (rd_data)
    );

    assign cnt16 = 16'(cnt_lat_q);

    always_comb begin
        next_byte = '0;
        case (state_q)
            RD_HDR: begin
                case (hdr_idx_q)
                    3'd0:    next_byte = SYNC0_BYTE;
                    3'd1:    next_byte = SYNC1_BYTE;
                    3'd2:    next_byte = seq_q;
                    3'd3:    next_byte = flags_byte(trunc_lat_q);
                    3'd4:    next_byte = cnt16[15:8];
                    3'd5:    next_byte = cnt16[7:0];
                    3'd6:    next_byte = {6'b0, dust_lat_q[9:8]};
                    default: next_byte = dust_lat_q[7:0];
                endcase
            end
            RD_PT: begin
                case (byte_sel_q)
                    2'd0:    next_byte = rd_data[31:24];
                    2'd1:    next_byte = pt_buf_q[23:16];
                    2'd2:    next_byte = pt_buf_q[15:8];
                    default: next_byte = pt_buf_q[7:0];
                endcase
            end
`ifdef SCAN_FRAME_CHECKSUM_EN
            RD_CSUM: next_byte = csum_q;
`endif
            default: next_byte = '0;
        endcase
    end

`ifdef SCAN_FRAME_CHECKSUM_EN
    assign csum_en = (state_q == RD_PT) || ((state_q == RD_HDR) && (hdr_idx_q >= 3'd2));
`endif

    // The output byte register reloads whenever it is empty or being consumed;
    // last_q marks that the final byte is loaded and only its transfer remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RD_IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
            seq_q       <= '0;
            hdr_idx_q   <= '0;
            byte_sel_q  <= '0;
            pt_idx_q    <= '0;
            cnt_lat_q   <= '0;
            trunc_lat_q <= 1'b0;
            dust_lat_q  <= '0;
            rd_addr_q   <= '0;
            pt_buf_q    <= '0;
`ifdef SCAN_FRAME_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else if (start) begin
            state_q     <= RD_HDR;
            busy_q      <= 1'b1;
            last_q      <= 1'b0;
            hdr_idx_q   <= '0;
            byte_sel_q  <= '0;
            pt_idx_q    <= '0;
            rd_addr_q   <= '0;
            cnt_lat_q   <= wr_cnt_q;
            trunc_lat_q <= trunc_q;
            dust_lat_q  <= dust_cnt;
`ifdef SCAN_FRAME_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else if (!rd_idle) begin
            if (last_q) begin
                if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    state_q    <= RD_IDLE;
                    busy_q     <= 1'b0;
                    last_q     <= 1'b0;
                    seq_q      <= seq_q + 1'b1;
                end
            end else if (!tx_valid_q || tx_ready) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= next_byte;
`ifdef SCAN_FRAME_CHECKSUM_EN
                if (csum_en) begin
                    csum_q <= csum_q ^ next_byte;
                end
`endif
                case (state_q)
                    RD_HDR: begin
                        hdr_idx_q <= hdr_idx_q + 1'b1;
                        if (hdr_idx_q == 3'(HDR_LEN - 1)) begin
                            state_q <= RD_PT;
                        end
                    end
                    RD_PT: begin
                        byte_sel_q <= byte_sel_q + 1'b1;
                        if (byte_sel_q == 2'd0) begin
                            pt_buf_q  <= rd_data[23:0];
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                        if (byte_sel_q == 2'd3) begin
                            pt_idx_q <= pt_idx_q + 1'b1;
                            if ((pt_idx_q + 1'b1) == cnt_lat_q) begin
`ifdef SCAN_FRAME_CHECKSUM_EN
                                state_q <= RD_CSUM;
`else
                                last_q  <= 1'b1;
`endif
                            end
                        end
                    end
                    default: last_q <= 1'b1;
                endcase
            end
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign frame_busy = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_scan_frame_packer.sv
// Directed bench for scan_frame_packer: frame content, latency, backpressure,
// overflow, gating, saturation and asynchronous reset.
module tb_scan_frame_packer;

    localparam int MAXP = 1024;

    logic        clk = 1'b0, rst_n = 1'b0, send_en = 1'b0, zero_flag = 1'b0;
    logic        target_valid = 1'b0, tx_ready = 1'b1, bp_mode = 1'b0;
    logic [9:0]  dust_cnt = 10'h2AB;
    logic [15:0] target_pos = '0, target_gray = '0;
    logic        tx_valid, frame_busy, overflow;
    logic [7:0]  tx_data;

    int          n_checks = 0, n_fails = 0;
    int          cyc = 0, rc = 0, ovf_cnt = 0, first_x = 0, last_x = 0, ovf_snap = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] pts_q[$];
    logic        stall_q = 1'b0;
    logic [7:0]  held = '0;

    scan_frame_packer #(.MAX_POINTS(MAXP), .ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .send_en      (send_en),
        .zero_flag    (zero_flag),
        .dust_cnt     (dust_cnt),
        .target_valid (target_valid),
        .target_pos   (target_pos),
        .target_gray  (target_gray),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .frame_busy   (frame_busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        rc = rc + 1;
        tx_ready = bp_mode ? (rc % 3 == 0) : 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && stall_q) begin
            check_eq("stall_valid_held", {31'b0, tx_valid}, 32'd1);
            check_eq("stall_data_held", {24'b0, tx_data}, {24'b0, held});
        end
        if (rst_n && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            if (rx_q.size() == 1) first_x = cyc;
            last_x = cyc;
        end
        if (overflow) ovf_cnt++;
        stall_q = rst_n && tx_valid && !tx_ready;
        held    = tx_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_pts(input int n, input logic [15:0] p0, input logic [15:0] g0,
                            input logic [15:0] stride);
        for (int i = 0; i < n; i++) begin
            step();
            target_valid = 1'b1;
            target_pos   = p0 + 16'(i) * stride;
            target_gray  = g0 + 16'(i) * stride;
            if (pts_q.size() < MAXP) pts_q.push_back({target_pos, target_gray});
        end
        step();
        target_valid = 1'b0;
    endtask

    task automatic boundary();
        step();
        zero_flag = 1'b1;
        step();
        step();
        zero_flag = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        @(negedge clk);
        for (int i = 0; i < limit && frame_busy; i++) @(negedge clk);
        check_eq({tag, "_done"}, {31'b0, frame_busy}, 32'd0);
    endtask

    task automatic build_exp(input logic [7:0] seq, input logic trunc, input logic [9:0] dust);
        logic [15:0] n;
        logic [31:0] p;
        logic [7:0]  cs;
        n = 16'(pts_q.size());
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(seq);
        exp_q.push_back({7'b0, trunc});
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        exp_q.push_back({6'b0, dust[9:8]});
        exp_q.push_back(dust[7:0]);
        for (int i = 0; i < pts_q.size(); i++) begin
            p = pts_q[i];
            exp_q.push_back(p[31:24]);
            exp_q.push_back(p[23:16]);
            exp_q.push_back(p[15:8]);
            exp_q.push_back(p[7:0]);
        end
        cs = '0;
        for (int i = 2; i < exp_q.size(); i++) cs = cs ^ exp_q[i];
`ifdef SCAN_FRAME_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic compare_frame(input string tag);
        int bad;
        bad = 'hFFFF;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i] && bad == 'hFFFF) bad = i;
        end
        check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
        check_eq({tag, "_first_bad_idx"}, bad, 32'hFFFF);
        if (bad != 'hFFFF) $display("  %s byte %0d: got %02h want %02h", tag, bad, rx_q[bad], exp_q[bad]);
    endtask

    task automatic clear_all();
        rx_q.delete();
        pts_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check_eq("rst_busy", {31'b0, frame_busy}, 32'd0);
        check_eq("rst_overflow", {31'b0, overflow}, 32'd0);
        step();
        rst_n   = 1'b1;
        send_en = 1'b1;
        step();

        // single revolution, latency and gapless streaming
        clear_all();
        feed_pts(3, 16'h0102, 16'h0304, 16'h1010);
        build_exp(8'd0, 1'b0, dust_cnt);
        step();
        zero_flag = 1'b1;
        @(negedge clk);
        check_eq("f1_busy_pre", {31'b0, frame_busy}, 32'd0);
        @(negedge clk);
        check_eq("f1_busy_t1", {31'b0, frame_busy}, 32'd1);
        check_eq("f1_valid_t1", {31'b0, tx_valid}, 32'd0);
        @(negedge clk);
        check_eq("f1_valid_t2", {31'b0, tx_valid}, 32'd1);
        check_eq("f1_first_byte", {24'b0, tx_data}, 32'hA5);
        step();
        zero_flag = 1'b0;
        wait_done("f1", 200);
        compare_frame("f1");
        check_eq("f1_gapless", last_x - first_x + 1, rx_q.size());
        check_eq("f1_count_lo", {24'b0, rx_q[5]}, 32'h03);
        check_eq("f1_dust_lo", {24'b0, rx_q[7]}, 32'hAB);
`ifdef SCAN_FRAME_CHECKSUM_EN
        check_eq("f1_checksum", {24'b0, rx_q[20]}, 32'hAE);
`endif

        // backpressure: ready high one cycle in three
        clear_all();
        feed_pts(3, 16'h0102, 16'h0304, 16'h1010);
        build_exp(8'd1, 1'b0, dust_cnt);
        bp_mode = 1'b1;
        boundary();
        wait_done("f2", 400);
        bp_mode = 1'b0;
        compare_frame("f2");

        // overflow: boundary while the previous frame is still streaming
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        clear_all();
        ovf_cnt = 0;
        feed_pts(3, 16'h0A01, 16'h0B02, 16'h0101);
        build_exp(8'd0, 1'b0, dust_cnt);
        boundary();
        pts_q.delete();
        feed_pts(2, 16'hDD00, 16'hEE00, 16'h0001);
        boundary();
        wait_done("f3a", 400);
        compare_frame("f3a");
        check_eq("f3_ovf_pulses", ovf_cnt, 32'd1);
        clear_all();
        feed_pts(1, 16'h4455, 16'h6677, 16'h0001);
        build_exp(8'd1, 1'b0, dust_cnt);
        boundary();
        wait_done("f3c", 400);
        compare_frame("f3c");
        check_eq("f3_ovf_after", ovf_cnt, 32'd1);

        // point on the boundary cycle lands in the next frame as point 0
        clear_all();
        feed_pts(2, 16'h1234, 16'h5678, 16'h0100);
        build_exp(8'd2, 1'b0, dust_cnt);
        step();
        zero_flag    = 1'b1;
        target_valid = 1'b1;
        target_pos   = 16'hBEEF;
        target_gray  = 16'hCAFE;
        step();
        target_valid = 1'b0;
        step();
        zero_flag = 1'b0;
        wait_done("f4a", 400);
        compare_frame("f4a");
        rx_q.delete();
        pts_q.delete();
        pts_q.push_back(32'hBEEFCAFE);
        feed_pts(1, 16'h7777, 16'h8888, 16'h0001);
        build_exp(8'd3, 1'b0, dust_cnt);
        boundary();
        wait_done("f4b", 400);
        compare_frame("f4b");
        check_eq("f4b_pt0_hi", {24'b0, rx_q[8]}, 32'hBE);

        // send_en low at the boundary: silent discard
        clear_all();
        send_en  = 1'b0;
        ovf_snap = ovf_cnt;
        feed_pts(2, 16'h0F0F, 16'hF0F0, 16'h0001);
        boundary();
        repeat (30) @(negedge clk);
        check_eq("f5_gated_busy", {31'b0, frame_busy}, 32'd0);
        check_eq("f5_gated_bytes", rx_q.size(), 32'd0);
        check_eq("f5_gated_ovf", ovf_cnt, ovf_snap);
        send_en = 1'b1;
        clear_all();
        feed_pts(1, 16'hA1A2, 16'hB1B2, 16'h0001);
        build_exp(8'd4, 1'b0, dust_cnt);
        boundary();
        wait_done("f5", 400);
        compare_frame("f5");

        // saturation: MAX_POINTS+5 points
        clear_all();
        dust_cnt = 10'h155;
        feed_pts(MAXP + 5, 16'h0000, 16'h8000, 16'h0001);
        build_exp(8'd5, 1'b1, dust_cnt);
        boundary();
        wait_done("f6", 6000);
        compare_frame("f6");
        check_eq("f6_flags", {24'b0, rx_q[3]}, 32'h01);
        check_eq("f6_count_hi", {24'b0, rx_q[4]}, 32'h04);
        check_eq("f6_count_lo", {24'b0, rx_q[5]}, 32'h00);

        // asynchronous reset in the middle of the point bytes
        clear_all();
        feed_pts(3, 16'h3000, 16'h4000, 16'h0011);
        boundary();
        repeat (10) @(negedge clk);
        check_eq("f7_pre_rst_valid", {31'b0, tx_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("f7_rst_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("f7_rst_busy", {31'b0, frame_busy}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        clear_all();
        feed_pts(2, 16'h5150, 16'h6160, 16'h0202);
        build_exp(8'd0, 1'b0, dust_cnt);
        boundary();
        wait_done("f7", 400);
        compare_frame("f7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/scan_frame_packer.md
# scan_frame_packer

Consumer-side counterpart of the distance pipeline's target stream: collects the per-revolution `target_valid`/`target_pos`/`target_gray` points between successive `zero_flag` rising edges into a ping-pong point buffer. On each revolution boundary it emits the completed revolution as a framed byte stream with valid/ready handshake toward the host link transmitter (UART/Ethernet MAC byte port). It sits directly after `calc_distance_top` and alongside the register/command block that drives `send_en`.

## Interface

Parameters:
- `MAX_POINTS`, 1024: point capacity per bank; points beyond this are dropped.
- `ADDR_W`, 10: log2(`MAX_POINTS`).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `send_en`  in  1  host enable; when low, no new frame starts.
- `zero_flag`  in  1  revolution index level; its rising edge marks the revolution boundary.
- `dust_cnt`  in  10  dust counter, sampled at the boundary.
- `target_valid`  in  1  point strobe, one cycle per point.
- `target_pos`  in  16  point distance.
- `target_gray`  in  16  point intensity.
- `tx_valid`  out  1  byte available.
- `tx_data`  out  8  byte.
- `tx_ready`  in  1  downstream accepts the byte.
- `frame_busy`  out  1  frame emission in progress.
- `overflow`  out  1  one-cycle pulse when a completed revolution is discarded because the reader is busy.

## Operation

- **Writer:**
  - Each `target_valid` writes `{pos,gray}` to the write bank at `wr_cnt`, then increments `wr_cnt`.
  - At `wr_cnt == MAX_POINTS`, further writes are dropped and `trunc` is set.
- **Boundary** (registered rising edge of `zero_flag`):
  - If `send_en` is high, the reader is IDLE, and `wr_cnt > 0`: swap banks, latch `wr_cnt`, `trunc` and `dust_cnt`, and start a frame.
  - If the reader is busy: discard the revolution and pulse `overflow`.
  - If `send_en` is low or `wr_cnt == 0`: discard silently.
  - In every case, `wr_cnt` and `trunc` clear.
- **Frame byte order:**
  - 0xA5, 0x5A.
  - `seq[7:0]`.
  - flags: bit0 = `trunc`, others 0.
  - count hi, count lo.
  - `{6'b0, dust[9:8]}`, `dust[7:0]`.
  - Per point: pos hi, pos lo, gray hi, gray lo.
  - checksum.
- `seq` increments after each frame completes, wrapping 255→0.
- **Checksum:** XOR of every byte from `seq` through the last point byte.
- **Reader FSM:**
  - IDLE → HDR on frame start.
  - HDR → PT after 8 header bytes.
  - PT → CSUM after byte 4N.
  - CSUM → IDLE.
- **Simultaneous events:**
  - A `target_valid` in the boundary cycle belongs to the new revolution and is written to the new bank at address 0.
  - `send_en` falling mid-frame does not abort the frame in progress.

## Timing

- **Reset values:** `tx_valid`=0, `tx_data`=0, `frame_busy`=0, `overflow`=0, `seq`=0, `wr_cnt`=0, bank select 0, FSM IDLE.
- **Start latency:** `zero_flag` sampled high at cycle t (low at t-1) → banks swap at t+1 → `tx_valid` with 0xA5 at t+2.
- **Handshake:**
  - A byte transfers when `tx_valid && tx_ready`.
  - `tx_data` is held stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops before the transfer.
- **Throughput:** 1 byte/cycle with `tx_ready` held high. Point RAM read (1-cycle latency) is prefetched during header and previous-point bytes, so there are no bubbles.
- `frame_busy` is high from t+1 until the cycle after the last byte transfers.
- **Frame length:** 9 + 4N bytes.
- **Arithmetic:** `wr_cnt` is `ADDR_W+1` bits. The count field carries the saturated value (≤ `MAX_POINTS`), zero-extended to 16 bits.
- **Reset mid-frame:** output is abandoned immediately and the buffer content is ignored.

## Configuration

- `SCAN_FRAME_CHECKSUM_EN`:
  - Defined: the checksum byte is appended (9 + 4N bytes).
  - Undefined: the CSUM state and XOR accumulator are removed, and PT → IDLE directly after byte 4N (8 + 4N bytes).

## Structure

- **Package `scan_frame_pkg`:** header constants 0xA5/0x5A, header length 8, flag bit positions, reader state enum.
- **Sub-module `frame_pingpong_ram`:** two banks of `MAX_POINTS` × 32. Write port takes bank select and address; read port is the opposite bank with 1-cycle read latency.

## Test plan

- **Single revolution:** 3 points (pos 0x0102/gray 0x0304, 0x1112/0x1314, 0x2122/0x2324), `dust_cnt`=0x2AB, `tx_ready`=1, then `zero_flag` edge → bytes A5 5A 00 00 00 03 02 AB 01 02 03 04 11 12 13 14 21 22 23 24 followed by the XOR checksum. `tx_valid` asserts exactly 2 cycles after the edge, with no gaps.
- **Backpressure:** same frame with `tx_ready` toggling 1-in-3 → identical byte sequence; `tx_data` stable while stalled.
- **Overflow:** second revolution boundary while the first frame is still emitting → `overflow` pulses once; the next frame carries `seq`=1 and only points from the revolution after the discarded one.
- **Saturation:** `MAX_POINTS`+5 points in one revolution → count field = `MAX_POINTS`, flags bit0 = 1.
- **Boundary coincidence and gating:** `target_valid` in the boundary cycle → that point appears as point 0 of the next frame. `send_en`=0 at the boundary → no frame and no `overflow`.
- **Async reset mid-frame:** `rst_n` low during PT → `tx_valid`=0 immediately; after release, the next frame starts with `seq`=0.
